// File: rtl/fifo_upsizing_pkg.sv
// Shared constants and derivation helpers for the narrow-to-wide FIFO and its lane packer.
package fifo_upsizing_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic nearly_full;
    logic nearly_empty;
    logic one_from_full;
  } fifo_flags_t;

  function automatic int calc_ratio(input int w_in, input int w_out);
    return w_out / w_in;
  endfunction

  function automatic int calc_lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Tiny depths fall back to a fixed 4-entry FIFO with matching thresholds.
  function automatic bit small_depth(input int depth);
    return $clog2(depth) < 2;
  endfunction

  function automatic int calc_fifo_size(input int depth);
    return small_depth(depth) ? 4 : depth;
  endfunction

  function automatic int calc_nearly_full(input int depth, input int thresh);
    return small_depth(depth) ? 3 : thresh;
  endfunction

  function automatic int calc_nearly_empty(input int depth, input int thresh);
    return small_depth(depth) ? 1 : thresh;
  endfunction

endpackage

// File: rtl/fifo_upsize_pack.sv
// Lane packer: gathers narrow writes into a wide word and decides when to commit it.
module fifo_upsize_pack import fifo_upsizing_pkg::*; #(
  parameter int DATA_WIDTH_IN    = 32,
  parameter int DATA_WIDTH_OUT   = 128,
  parameter int EXTRA_DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_acc_i,
  input  logic [calc_lane_w(calc_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT))-1:0] wr_dst_i,
  input  logic wr_last_i,
  input  logic [DATA_WIDTH_IN+EXTRA_DATA_WIDTH-1:0] data_i,
  output logic commit_o,
  output logic [DATA_WIDTH_OUT+EXTRA_DATA_WIDTH-1:0] word_o,
  output logic pending_o
);

  localparam int RATIO  = calc_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int LANE_W = calc_lane_w(RATIO);

  logic [RATIO-1:0][DATA_WIDTH_IN-1:0] lanes_q, lanes_d, merged;
  logic [EXTRA_DATA_WIDTH-1:0] side_q, side_d;
  logic pending_q, pending_d;
  logic [LANE_W-1:0] dst;

  always_comb begin
    dst = (RATIO == 1) ? '0 : wr_dst_i;
    merged = lanes_q;
    for (int i = 0; i < RATIO; i++) begin
      if (wr_acc_i && dst == LANE_W'(i)) merged[i] = data_i[DATA_WIDTH_IN-1:0];
    end
    commit_o = wr_acc_i && (dst == LANE_W'(RATIO - 1) || wr_last_i);
    side_d   = wr_acc_i ? data_i[DATA_WIDTH_IN+EXTRA_DATA_WIDTH-1:DATA_WIDTH_IN] : side_q;
    word_o   = {side_d, merged};
    lanes_d   = lanes_q;
    pending_d = pending_q;
    if (commit_o) begin
      lanes_d   = '0;
      pending_d = 1'b0;
    end else if (wr_acc_i) begin
      lanes_d   = merged;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q   <= '0;
      side_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      lanes_q   <= lanes_d;
      side_q    <= side_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/ram_block.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module RAM_BLOCK #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_upsizing.sv
// Upsizing FIFO: narrow lane writes are packed into wide words, stored, and read out registered.
module fifo_upsizing import fifo_upsizing_pkg::*; #(
  parameter int MEM_DEPTH           = 1024,
  parameter int DATA_WIDTH_IN       = 32,
  parameter int DATA_WIDTH_OUT      = 128,
  parameter int EXTRA_DATA_WIDTH    = 8,
  parameter int NEARLY_FULL_THRESH  = 512,
  parameter int NEARLY_EMPTY_THRESH = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [calc_lane_w(calc_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT))-1:0] wr_dst,
  input  logic wr_last,
  input  logic [DATA_WIDTH_IN+EXTRA_DATA_WIDTH-1:0] data_in,
  input  logic rd_en,
  input  logic data_hold,
  output logic [DATA_WIDTH_OUT+EXTRA_DATA_WIDTH-1:0] data_out,
  output logic fifo_full,
  output logic fifo_empty,
  output logic fifo_nearly_full,
  output logic fifo_nearly_empty,
  output logic fifo_one_from_full,
  output logic pack_pending
);

  localparam int FIFO_SIZE    = calc_fifo_size(MEM_DEPTH);
  localparam int NEARLY_FULL  = calc_nearly_full(MEM_DEPTH, NEARLY_FULL_THRESH);
  localparam int NEARLY_EMPTY = calc_nearly_empty(MEM_DEPTH, NEARLY_EMPTY_THRESH);
  localparam int PTR_W        = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  localparam int CNT_W        = $clog2(FIFO_SIZE + 1);
  localparam int WORD_W       = DATA_WIDTH_OUT + EXTRA_DATA_WIDTH;

  logic              wr_acc, pop, commit;
  logic [WORD_W-1:0] commit_word, ram_rdata, head, dout_q, dout_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_flags_t       flags_q, flags_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_acc = wr_en && !flags_q.full;
  assign pop    = rd_en && !flags_q.empty;

  fifo_upsize_pack #(
    .DATA_WIDTH_IN   (DATA_WIDTH_IN),
    .DATA_WIDTH_OUT  (DATA_WIDTH_OUT),
    .EXTRA_DATA_WIDTH(EXTRA_DATA_WIDTH)
  ) u_pack (
    .clk      (clk),
    .rst      (rst),
    .wr_acc_i (wr_acc),
    .wr_dst_i (wr_dst),
    .wr_last_i(wr_last),
    .data_i   (data_in),
    .commit_o (commit),
    .word_o   (commit_word),
    .pending_o(pack_pending)
  );

  RAM_BLOCK #(
    .DEPTH (FIFO_SIZE),
    .ADDR_W(PTR_W),
    .DATA_W(WORD_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (commit),
    .waddr_i(wr_ptr_q),
    .wdata_i(commit_word),
    .raddr_i(rd_ptr_d),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    wr_ptr_d = commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({commit, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The word being written this edge is not yet visible through the RAM read port.
    head   = (commit && wr_ptr_q == rd_ptr_d) ? commit_word : ram_rdata;
    dout_d = dout_q;
    if (!data_hold && count_d != '0) dout_d = head;
    flags_d.full          = (count_d == CNT_W'(FIFO_SIZE));
    flags_d.empty         = (count_d == '0);
    flags_d.nearly_full   = (count_d >= CNT_W'(NEARLY_FULL));
    flags_d.nearly_empty  = (count_d <= CNT_W'(NEARLY_EMPTY));
    flags_d.one_from_full = (count_d == CNT_W'(FIFO_SIZE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      flags_q  <= '{full: 1'b0, empty: 1'b1, nearly_full: 1'b0,
                    nearly_empty: 1'b1, one_from_full: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      flags_q  <= flags_d;
    end
  end

  assign data_out           = dout_q;
  assign fifo_full          = flags_q.full;
  assign fifo_empty         = flags_q.empty;
  assign fifo_nearly_full   = flags_q.nearly_full;
  assign fifo_nearly_empty  = flags_q.nearly_empty;
  assign fifo_one_from_full = flags_q.one_from_full;

endmodule
